// File: rtl/fp_cmp_arb.sv
// Round-robin arbiter sharing one start/done floating-point compare unit among
// N_REQ requesters, with registered operand/result paths and a done watchdog.
module fp_cmp_arb #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [2*N_REQ-1:0]        req_fn,
    input  logic [N_REQ*DATA_W-1:0]   req_op_a,
    input  logic [N_REQ*DATA_W-1:0]   req_op_b,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic                      rsp_res,
    output logic                      rsp_err,
    output logic                      cmp_start,
    output logic [1:0]                cmp_fn,
    output logic [DATA_W-1:0]         cmp_op_a,
    output logic [DATA_W-1:0]         cmp_op_b,
    input  logic                      cmp_done,
    input  logic                      cmp_res,
    output logic                      busy
);

    localparam int unsigned NR = N_REQ;
    localparam int GW = $clog2(N_REQ);
    localparam int CW = 8;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t              r_state, w_nxt_state;
    logic [GW-1:0]       r_last, w_nxt_last;
    logic [GW-1:0]       r_owner, w_nxt_owner;
    logic [CW-1:0]       r_cnt, w_nxt_cnt;
    logic [N_REQ-1:0]    r_ready, w_nxt_ready;
    logic [N_REQ-1:0]    r_rsp_valid, w_nxt_rsp_valid;
    logic                r_rsp_res, w_nxt_rsp_res;
    logic                r_rsp_err, w_nxt_rsp_err;
    logic                r_start, w_nxt_start;
    logic [1:0]          r_fn, w_nxt_fn;
    logic [DATA_W-1:0]   r_op_a, w_nxt_op_a;
    logic [DATA_W-1:0]   r_op_b, w_nxt_op_b;
    logic                r_busy, w_nxt_busy;

    logic [1:0]          w_fn_arr [N_REQ];
    logic [DATA_W-1:0]   w_a_arr  [N_REQ];
    logic [DATA_W-1:0]   w_b_arr  [N_REQ];
    logic                w_found;
    logic [GW-1:0]       w_win;
    int unsigned         w_idx;

    always_comb begin
        for (int unsigned i = 0; i < NR; i++) begin
            w_fn_arr[i] = req_fn[2*i +: 2];
            w_a_arr[i]  = req_op_a[i*DATA_W +: DATA_W];
            w_b_arr[i]  = req_op_b[i*DATA_W +: DATA_W];
        end
    end

    // Scan upward from last_grant+1 with wrap; the first valid requester wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int unsigned i = 0; i < NR; i++) begin
            w_idx = 32'(r_last) + 32'd1 + i;
            if (w_idx >= NR) w_idx = w_idx - NR;
            if (!w_found && req_valid[w_idx[GW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[GW-1:0];
            end
        end
    end

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_last      = r_last;
        w_nxt_owner     = r_owner;
        w_nxt_cnt       = r_cnt;
        w_nxt_ready     = '0;
        w_nxt_rsp_valid = '0;
        w_nxt_rsp_res   = 1'b0;
        w_nxt_rsp_err   = 1'b0;
        w_nxt_start     = 1'b0;
        w_nxt_fn        = r_fn;
        w_nxt_op_a      = r_op_a;
        w_nxt_op_b      = r_op_b;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_nxt_state        = S_BUSY;
                    w_nxt_last         = w_win;
                    w_nxt_owner        = w_win;
                    w_nxt_cnt          = '0;
                    w_nxt_ready[w_win] = 1'b1;
                    w_nxt_start        = 1'b1;
                    w_nxt_fn           = w_fn_arr[w_win];
                    w_nxt_op_a         = w_a_arr[w_win];
                    w_nxt_op_b         = w_b_arr[w_win];
                end
            end
            S_BUSY: begin
                // A done coinciding with the timeout takes priority over the error.
                if (cmp_done) begin
                    w_nxt_state              = S_IDLE;
                    w_nxt_rsp_valid[r_owner] = 1'b1;
                    w_nxt_rsp_res            = cmp_res;
                end else if (r_cnt == CW'(TIMEOUT)) begin
                    w_nxt_state              = S_IDLE;
                    w_nxt_rsp_valid[r_owner] = 1'b1;
                    w_nxt_rsp_err            = 1'b1;
                end else begin
                    w_nxt_cnt = r_cnt + CW'(1);
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
        w_nxt_busy = (w_nxt_state == S_BUSY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last      <= GW'(N_REQ - 1);
            r_owner     <= '0;
            r_cnt       <= '0;
            r_ready     <= '0;
            r_rsp_valid <= '0;
            r_rsp_res   <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_start     <= 1'b0;
            r_fn        <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_last      <= w_nxt_last;
            r_owner     <= w_nxt_owner;
            r_cnt       <= w_nxt_cnt;
            r_ready     <= w_nxt_ready;
            r_rsp_valid <= w_nxt_rsp_valid;
            r_rsp_res   <= w_nxt_rsp_res;
            r_rsp_err   <= w_nxt_rsp_err;
            r_start     <= w_nxt_start;
            r_fn        <= w_nxt_fn;
            r_op_a      <= w_nxt_op_a;
            r_op_b      <= w_nxt_op_b;
            r_busy      <= w_nxt_busy;
        end
    end

    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_res   = r_rsp_res;
    assign rsp_err   = r_rsp_err;
    assign cmp_start = r_start;
    assign cmp_fn    = r_fn;
    assign cmp_op_a  = r_op_a;
    assign cmp_op_b  = r_op_b;
    assign busy      = r_busy;

endmodule

// File: tb/tb_fp_cmp_arb.sv
// Directed bench for fp_cmp_arb: expected responses are queued at grant time
// and matched against rsp_valid/rsp_res/rsp_err by a negedge monitor.
module tb_fp_cmp_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TO = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [2*N-1:0]    req_fn = '0;
    logic [N*DW-1:0]   req_op_a = '0;
    logic [N*DW-1:0]   req_op_b = '0;
    logic [N-1:0]      req_ready, rsp_valid;
    logic              rsp_res, rsp_err, cmp_start, busy;
    logic [1:0]        cmp_fn;
    logic [DW-1:0]     cmp_op_a, cmp_op_b;
    logic              cmp_done, cmp_res;

    logic              u_done = 1'b0;
    logic              u_res = 1'b0;
    logic              u_pres = 1'b0;
    logic              u_act = 1'b0;
    int                u_rem = 0;
    int                u_lat = 1;
    logic              u_en = 1'b1;
    logic              inj_done = 1'b0;

    typedef struct packed {
        logic [N-1:0] v;
        logic         res;
        logic         err;
    } rsp_t;

    rsp_t sb_q[$];
    rsp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    fp_cmp_arb #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_fn(req_fn),
        .req_op_a(req_op_a), .req_op_b(req_op_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_res(rsp_res), .rsp_err(rsp_err),
        .cmp_start(cmp_start), .cmp_fn(cmp_fn),
        .cmp_op_a(cmp_op_a), .cmp_op_b(cmp_op_b),
        .cmp_done(cmp_done), .cmp_res(cmp_res),
        .busy(busy)
    );

    always #5 clk = ~clk;

    assign cmp_done = u_done | inj_done;
    assign cmp_res  = u_res;

    function automatic logic f_lt(input logic [31:0] a, input logic [31:0] b);
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 1'b0;
        if (a[31] != b[31]) return a[31];
        if (!a[31]) return (a[30:0] < b[30:0]);
        return (a[30:0] > b[30:0]);
    endfunction

    function automatic logic f_cmp(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b);
        if (fn[1]) return (a == b) || (a[30:0] == 31'd0 && b[30:0] == 31'd0);
        if (fn[0]) return f_lt(a, b);
        return f_lt(a, b) || (a == b);
    endfunction

    // Compare unit with programmable start-to-done latency.
    always @(posedge clk) begin
        u_done <= 1'b0;
        if (cmp_start && u_en) begin
            if (u_lat == 1) begin
                u_done <= 1'b1;
                u_res  <= f_cmp(cmp_fn, cmp_op_a, cmp_op_b);
            end else begin
                u_rem  <= u_lat - 1;
                u_act  <= 1'b1;
                u_pres <= f_cmp(cmp_fn, cmp_op_a, cmp_op_b);
            end
        end else if (u_act) begin
            if (u_rem == 1) begin
                u_done <= 1'b1;
                u_res  <= u_pres;
                u_act  <= 1'b0;
            end
            u_rem <= u_rem - 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid != '0) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", 64'(rsp_valid), 64'(0));
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sb_rsp_valid", 64'(rsp_valid), 64'(mon_e.v));
                    check("sb_rsp_res", 64'(rsp_res), 64'(mon_e.res));
                    check("sb_rsp_err", 64'(rsp_err), 64'(mon_e.err));
                end
            end else begin
                check("rsp_quiet", 64'({rsp_res, rsp_err}), 64'(0));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b);
        req_fn[2*i +: 2]    = fn;
        req_op_a[i*DW +: DW] = a;
        req_op_b[i*DW +: DW] = b;
    endtask

    task automatic outs_zero(input string tag);
        check({tag, "_ready"}, 64'(req_ready), 64'(0));
        check({tag, "_rspv"}, 64'(rsp_valid), 64'(0));
        check({tag, "_res_err"}, 64'({rsp_res, rsp_err}), 64'(0));
        check({tag, "_start"}, 64'(cmp_start), 64'(0));
        check({tag, "_fn"}, 64'(cmp_fn), 64'(0));
        check({tag, "_ops"}, {cmp_op_a, cmp_op_b}, 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b1;
        step();
        step();
        outs_zero("reset");
        rst = 1'b0;
    endtask

    // Checks the grant cycle and queues the response this grant should produce.
    task automatic grant_chk(input string tag, input int w, input logic [1:0] fn,
                             input logic [31:0] a, input logic [31:0] b, input logic to_exp);
        rsp_t e;
        check({tag, "_ready"}, 64'(req_ready), 64'(4'b0001 << w));
        check({tag, "_start"}, 64'(cmp_start), 64'(1));
        check({tag, "_busy"}, 64'(busy), 64'(1));
        check({tag, "_fn"}, 64'(cmp_fn), 64'(fn));
        check({tag, "_ops"}, {cmp_op_a, cmp_op_b}, {a, b});
        e.v   = 4'(4'b0001 << w);
        e.res = to_exp ? 1'b0 : f_cmp(fn, a, b);
        e.err = to_exp;
        sb_q.push_back(e);
    endtask

    initial begin
        // Single lt request from requester 2.
        do_reset();
        set_req(2, 2'b01, 32'hBF800000, 32'h3F800000);
        req_valid = 4'b0100;
        step();
        grant_chk("t1_grant", 2, 2'b01, 32'hBF800000, 32'h3F800000, 1'b0);
        req_valid = '0;
        step();
        check("t1_start_drop", 64'({cmp_start, req_ready}), 64'(0));
        check("t1_busy_hold", 64'(busy), 64'(1));
        step();
        check("t1_rsp", 64'({rsp_valid, rsp_res, rsp_err}), 64'({4'b0100, 1'b1, 1'b0}));
        check("t1_idle", 64'(busy), 64'(0));
        step();

        // Everyone valid: grants rotate 0,1,2,3,0 every third cycle.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 2'b10, 32'h40000000, 32'h40000000);
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            step();
            grant_chk("t2_grant", k % N, 2'b10, 32'h40000000, 32'h40000000, 1'b0);
            if (k == 4) req_valid = '0;
            step();
            step();
        end
        step();

        // last_grant=1 with 1 and 3 pending: 3 first, then only 1.
        do_reset();
        set_req(1, 2'b00, 32'h3F800000, 32'h3F800000);
        set_req(3, 2'b01, 32'h40000000, 32'h3F800000);
        req_valid = 4'b0010;
        step();
        grant_chk("t3_g1", 1, 2'b00, 32'h3F800000, 32'h3F800000, 1'b0);
        req_valid = '0;
        step();
        step();
        req_valid = 4'b1010;
        step();
        grant_chk("t3_g3", 3, 2'b01, 32'h40000000, 32'h3F800000, 1'b0);
        req_valid = 4'b0010;
        step();
        step();
        step();
        grant_chk("t3_g1b", 1, 2'b00, 32'h3F800000, 32'h3F800000, 1'b0);
        step();
        step();
        step();
        grant_chk("t3_g1c", 1, 2'b00, 32'h3F800000, 32'h3F800000, 1'b0);
        req_valid = '0;
        step();
        step();
        step();

        // Unit never answers: watchdog response, then a late done is ignored.
        u_en = 1'b0;
        set_req(0, 2'b01, 32'h3F800000, 32'h40000000);
        req_valid = 4'b0001;
        step();
        grant_chk("t4_grant", 0, 2'b01, 32'h3F800000, 32'h40000000, 1'b1);
        req_valid = '0;
        repeat (14) step();
        step();
        check("t4_wait_rsp", 64'(rsp_valid), 64'(0));
        check("t4_wait_busy", 64'(busy), 64'(1));
        step();
        check("t4_to_rsp", 64'({rsp_valid, rsp_res, rsp_err}), 64'({4'b0001, 1'b0, 1'b1}));
        check("t4_to_idle", 64'(busy), 64'(0));
        step();
        inj_done = 1'b1;
        step();
        inj_done = 1'b0;
        check("t4_late_done", 64'(rsp_valid), 64'(0));
        step();
        check("t4_late_quiet", 64'({rsp_valid, busy}), 64'(0));
        u_en = 1'b1;

        // Reset during BUSY drops the compare; requester 0 then has priority.
        set_req(2, 2'b10, 32'h00001234, 32'h00001234);
        req_valid = 4'b0100;
        step();
        check("t5_pre_ready", 64'(req_ready), 64'(4'b0100));
        rst = 1'b1;
        #1;
        outs_zero("t5_async");
        step();
        set_req(0, 2'b00, 32'hC0000000, 32'h3F800000);
        rst = 1'b0;
        req_valid = 4'b0101;
        step();
        grant_chk("t5_g0", 0, 2'b00, 32'hC0000000, 32'h3F800000, 1'b0);
        req_valid = 4'b0100;
        step();
        step();
        step();
        grant_chk("t5_g2", 2, 2'b10, 32'h00001234, 32'h00001234, 1'b0);
        req_valid = '0;
        step();
        step();
        step();

        // Done lands exactly when the counter reaches TIMEOUT: done wins.
        u_lat = TO;
        set_req(1, 2'b10, 32'h40490FDB, 32'h40490FDB);
        req_valid = 4'b0010;
        step();
        grant_chk("t6_grant", 1, 2'b10, 32'h40490FDB, 32'h40490FDB, 1'b0);
        req_valid = '0;
        repeat (14) step();
        step();
        check("t6_wait_rsp", 64'(rsp_valid), 64'(0));
        step();
        check("t6_rsp", 64'({rsp_valid, rsp_res, rsp_err}), 64'({4'b0010, 1'b1, 1'b0}));
        step();
        u_lat = 1;
        step();

        check("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
